// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet path.
// Also used by the transmit CRC generator.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    PT_SPECIAL = 2'b00,
    PT_TOKEN   = 2'b01,
    PT_HSHAKE  = 2'b10,
    PT_DATA    = 2'b11
  } pid_type_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHAKE, S_FLUSH
  } state_e;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_rx_crc.sv
// Serial USB CRC5 and CRC16, MSB-feedback form, with residual-match outputs.
// The same shift form serves the transmit side (send the inverted register, MSB first).
module usb_rx_crc
  import usb_rx_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic in_bit,
  output logic crc5_ok,
  output logic crc16_ok
);

  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        fb5, fb16;

  assign fb5  = in_bit ^ crc5[4];
  assign fb16 = in_bit ^ crc16[15];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc5  <= 5'h1F;
      crc16 <= 16'hFFFF;
    end else if (clr) begin
      crc5  <= 5'h1F;
      crc16 <= 16'hFFFF;
    end else if (en) begin
      crc5  <= {crc5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'h00);
      crc16 <= {crc16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
    end
  end

  assign crc5_ok  = (crc5 == CRC5_RESIDUAL);
  assign crc16_ok = (crc16 == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_rx_packet_assembler.sv
// Assembles de-stuffed USB bits into PID/token/data bytes, checks PID and CRC,
// and reports one end-of-packet status strobe per packet.
module usb_rx_packet_assembler
  import usb_rx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_active,
  input  logic       bs_sending,
  input  logic       in_bit,
  output logic [3:0] pid,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       err_pid,
  output logic       err_crc,
  output logic       err_len,
  output logic       rx_busy
);

  localparam int PCW = $clog2(MAX_PAYLOAD + 1);

  state_e         state;
  logic [7:0]     sh, byte0, d0, d1, nbyte;
  logic [2:0]     bit_cnt;
  logic [1:0]     byte_cnt, fill;
  logic [PCW-1:0] pay_cnt;
  logic           f_pid, f_crc, f_len;
  logic           accept, byte_done, crc_en, crc5_ok, crc16_ok;
  logic           e_crc, e_len;

  assign accept    = rx_active & bs_sending;
  assign nbyte     = {in_bit, sh[7:1]};
  assign byte_done = accept & (bit_cnt == 3'd7);
  assign crc_en    = accept & (state inside {S_TOKEN, S_DATA, S_HSHAKE});
  assign rx_busy   = (state != S_IDLE);

  usb_rx_crc u_crc (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (state == S_IDLE),
    .en       (crc_en),
    .in_bit   (in_bit),
    .crc5_ok  (crc5_ok),
    .crc16_ok (crc16_ok)
  );

  // Final error picture at end of packet, folding in the length/CRC checks.
  always_comb begin
    e_len = f_len | (bit_cnt != 3'd0);
    e_crc = f_crc;
    if (state == S_TOKEN) begin
      e_len = e_len | (byte_cnt != 2'd2);
      e_crc = e_crc | !crc5_ok;
    end
    if (state == S_DATA) begin
      e_len = e_len | (byte_cnt < 2'd2);
      e_crc = e_crc | !crc16_ok;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sh         <= '0;
      byte0      <= '0;
      d0         <= '0;
      d1         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      fill       <= '0;
      pay_cnt    <= '0;
      f_pid      <= 1'b0;
      f_crc      <= 1'b0;
      f_len      <= 1'b0;
      pid        <= '0;
      addr       <= '0;
      endp       <= '0;
      data_byte  <= '0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_ok     <= 1'b0;
      err_pid    <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_ok     <= 1'b0;
      err_pid    <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      if (accept) begin
        sh      <= nbyte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      case (state)
        S_IDLE: if (accept) begin
          state    <= S_PID;
          f_pid    <= 1'b0;
          f_crc    <= 1'b0;
          f_len    <= 1'b0;
          byte_cnt <= '0;
          fill     <= '0;
          pay_cnt  <= '0;
        end
        S_FLUSH: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
        end
        default: if (!rx_active) begin
          state    <= S_FLUSH;
          pkt_done <= 1'b1;
          err_pid  <= f_pid;
          err_crc  <= e_crc;
          err_len  <= e_len;
          pkt_ok   <= !(f_pid | e_crc | e_len);
        end else begin
          if (accept && state == S_HSHAKE) f_len <= 1'b1;
          if (byte_done) begin
            if (state != S_PID && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            case (state)
              S_PID: begin
                pid <= nbyte[3:0];
                if (nbyte[7:4] != ~nbyte[3:0]) f_pid <= 1'b1;
                case (pid_type_e'(nbyte[1:0]))
                  PT_TOKEN:  state <= S_TOKEN;
                  PT_DATA:   state <= S_DATA;
                  PT_HSHAKE: state <= S_HSHAKE;
                  default: begin
                    state <= S_HSHAKE;
                    f_pid <= 1'b1;
                  end
                endcase
              end
              S_TOKEN: begin
                if (byte_cnt == 2'd0) byte0 <= nbyte;
                if (byte_cnt == 2'd1) begin
                  addr <= byte0[6:0];
                  endp <= {nbyte[2:0], byte0[7]};
                end
              end
              S_DATA: begin
                // Two-byte delay line keeps the trailing CRC bytes from being emitted.
                if (fill == 2'd2) begin
                  if (pay_cnt < PCW'(MAX_PAYLOAD)) begin
                    data_valid <= 1'b1;
                    data_byte  <= d1;
                    pay_cnt    <= pay_cnt + 1'b1;
                  end else begin
                    f_len <= 1'b1;
                  end
                end else begin
                  fill <= fill + 2'd1;
                end
                d1 <= d0;
                d0 <= nbyte;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
